rr_txn_arbiter: RTL and testbench
=================================

Name: rr_txn_arbiter

Overview:
- Round-robin, transaction-granular arbiter sharing one downstream channel (e.g. a memory port) among NUM_REQ requesters.
- Produces a one-hot grant plus the binary mux select that steers the shared datapath mux.
- Grant is held from arbitration until the granted requester's last beat is accepted.

Parameters:
- NUM_REQ, 4: number of requesters; legal values are 1, 2, 4 and 8. Any other value is an elaboration error.
- SEL_W, 2: mux-select width. Equals max(1, log2(NUM_REQ)).
- CNT_W, 16: width of each grant counter. Used only with ARB_STATS_EN.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- req, in, NUM_REQ: per-requester request. Level-sensitive.
- xfer_valid, in, 1: valid of the muxed (granted) source.
- xfer_ready, in, 1: ready of the downstream channel.
- xfer_last, in, 1: last beat of the current transaction.
- grant, out, NUM_REQ: one-hot grant; all zero when idle.
- grant_sel, out, SEL_W: binary index of the set grant bit; 0 when idle.
- grant_active, out, 1: high when any grant is held.
- stats_clr, in, 1: synchronous clear of the grant counters.
- grant_count, out, NUM_REQ*CNT_W: per-requester grant counts. Requester i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (async assert):
  - grant=0, grant_sel=0, grant_active=0, rr_ptr=0, state=IDLE, all counters=0.
  - A reset mid-transaction drops the grant immediately, without waiting for a clock.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If req!=0, pick winner w = first set req bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register grant=1<<w, grant_sel=w, state=BUSY.
  - Latency: req high at edge t gives grant visible after edge t (one cycle). No combinational path from req to grant.
- BUSY:
  - Grant holds regardless of req, including when the granted req deasserts.
  - Transaction completes on an edge with xfer_valid & xfer_ready & xfer_last.
- Completion edge:
  - rr_ptr <= (w+1) mod NUM_REQ.
  - Re-arbitrate on the same edge using the new pointer and the current req vector. The just-finished requester therefore has lowest priority.
  - If req!=0, the new grant takes effect with zero bubble. Otherwise grant clears and state goes to IDLE.
- Beats without xfer_last, or with valid & !ready, do not change state.
- NUM_REQ=1: grant=req-driven hold as above; grant_sel is tied 0.
- grant_sel and grant are always mutually consistent and change on the same edge.
- grant_active equals (state==BUSY).
- xfer_* inputs are ignored in IDLE.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Each grant issue (IDLE->BUSY or re-grant on completion) increments grant_count[w] by 1.
  - Counters saturate at all-ones.
  - stats_clr zeroes all counters. If stats_clr coincides with a grant, the counter clears to 0 (clear wins).
- Undefined:
  - No counter flops are built; grant_count is driven to 0 and stats_clr is ignored.
  - Ports stay present so instantiations do not change.

Decomposition:
- Shared package arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - function sel_width(n) returning max(1, clog2(n));
  - localparam DEFAULT_CNT_W=16.
- One sub-module: rr_priority_pick.
  - Combinational.
  - Inputs: req and ptr. Outputs: one-hot winner, binary index, any.
  - Used by both the IDLE and completion paths.

Test Plan:
- Reset then req=4'b0101 held, single-beat transactions (valid=ready=last=1 every cycle): grant sequence 0001, 0100, 0001, 0100, with grant_sel 0, 2, 0, 2 and no idle cycles between grants.
- Granted requester 1 issues a 3-beat transaction with ready low on beat 2 for 2 cycles: grant stays 0010 for all 5 cycles. Release occurs only on the edge where last, valid and ready are all high.
- req=4'b1111 with rr_ptr=3 after a grant to 2: next grants are 3, 0, 1, 2 in that order.
- Granted req drops mid-transaction: grant is held until last is accepted. It then clears to 0 and grant_active=0 if req=0.
- rst_n asserted asynchronously between edges while BUSY: grant=0, grant_active=0 immediately. After release, req=4'b1000 yields grant 1000 one cycle later, with rr_ptr back at 0.
- ARB_STATS_EN, CNT_W=4: 17 grants to requester 0 give grant_count[0]=15 (saturated). stats_clr pulsed on a grant edge gives 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin transaction arbiter.
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int DEFAULT_CNT_W = 16;

  // Mux-select width: at least one bit, even for a single requester.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set req bit scanning from ptr
// upward, modulo NUM_REQ. Returns one-hot winner, its binary index and any.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = sel_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [SEL_W-1:0]   index,
  output logic               any
);

  logic [NUM_REQ-1:0] req_rot;
  logic [SEL_W-1:0]   offset;

  // req_rot[k] is the request that sits k positions after the pointer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign req_rot[gi] = req[SEL_W'(ptr + gi)];
  end

  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = SEL_W'(k);
    end
  end

  assign any   = |req;
  assign index = (NUM_REQ == 1) ? '0 : SEL_W'(ptr + offset);

  always_comb begin
    winner = '0;
    if (any) winner[index] = 1'b1;
  end

endmodule

// File: rtl/rr_txn_arbiter.sv
// Round-robin arbiter that holds a grant for a whole transaction (until the last
// beat is accepted). Optional per-requester grant counters under ARB_STATS_EN.
module rr_txn_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic                     xfer_valid,
  input  logic                     xfer_ready,
  input  logic                     xfer_last,
  output logic [NUM_REQ-1:0]       grant,
  output logic [SEL_W-1:0]         grant_sel,
  output logic                     grant_active,
  input  logic                     stats_clr,
  output logic [NUM_REQ*CNT_W-1:0] grant_count
);

  if (!(NUM_REQ == 1 || NUM_REQ == 2 || NUM_REQ == 4 || NUM_REQ == 8)) begin : g_bad_num_req
    $error("rr_txn_arbiter: NUM_REQ must be 1, 2, 4 or 8");
  end
  if (SEL_W != sel_width(NUM_REQ)) begin : g_bad_sel_w
    $error("rr_txn_arbiter: SEL_W must equal max(1, clog2(NUM_REQ))");
  end

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] pick_winner;
  logic [SEL_W-1:0]   pick_index;
  logic               pick_any;
  logic               done;
  logic               issue;

  assign done = (state_reg == BUSY) && xfer_valid && xfer_ready && xfer_last;

  // On completion the pointer moves past the finished requester before the
  // same-edge re-arbitration, so one picker serves both the idle and re-grant paths.
  assign ptr_next = done ? SEL_W'((int'(sel_reg) + 1) % NUM_REQ) : ptr_reg;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_next),
    .winner (pick_winner),
    .index  (pick_index),
    .any    (pick_any)
  );

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    sel_next   = sel_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next = BUSY;
          grant_next = pick_winner;
          sel_next   = pick_index;
          issue      = 1'b1;
        end
      end
      BUSY: begin
        if (done) begin
          if (pick_any) begin
            grant_next = pick_winner;
            sel_next   = pick_index;
            issue      = 1'b1;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            sel_next   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      sel_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign grant        = grant_reg;
  assign grant_sel    = sel_reg;
  assign grant_active = (state_reg == BUSY);

`ifdef ARB_STATS_EN
  // Saturating counters; a clear on the same edge as a grant wins.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (stats_clr) begin
        cnt_reg <= '0;
      end else if (issue && pick_winner[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
    assign grant_count[gi*CNT_W +: CNT_W] = cnt_reg;
  end
`else
  logic [1:0] unused_stats;
  assign unused_stats = {stats_clr, issue};
  assign grant_count  = '0;
`endif

endmodule

// File: tb/tb_rr_txn_arbiter.sv
// Directed self-checking bench for rr_txn_arbiter (NUM_REQ=4, CNT_W=4).
module tb_rr_txn_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic                     xfer_valid = 1'b0;
  logic                     xfer_ready = 1'b0;
  logic                     xfer_last = 1'b0;
  logic [NUM_REQ-1:0]       grant;
  logic [SEL_W-1:0]         grant_sel;
  logic                     grant_active;
  logic                     stats_clr = 1'b0;
  logic [NUM_REQ*CNT_W-1:0] grant_count;

  int total = 0;
  int bad   = 0;

  rr_txn_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .xfer_valid   (xfer_valid),
    .xfer_ready   (xfer_ready),
    .xfer_last    (xfer_last),
    .grant        (grant),
    .grant_sel    (grant_sel),
    .grant_active (grant_active),
    .stats_clr    (stats_clr),
    .grant_count  (grant_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] s);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_sel"}, 32'(grant_sel), 32'(s));
    check({tag, "_active"}, 32'(grant_active), 32'(g != 4'b0000));
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_xfer(input logic v, input logic r, input logic l);
    xfer_valid = v;
    xfer_ready = r;
    xfer_last  = l;
  endtask

  initial begin
    step();
    step();
    expect_grant("reset", 4'b0000, 2'd0);
    check("reset_count", grant_count, 32'd0);
    rst_n = 1'b1;

    // Single-beat transactions alternate between requesters 0 and 2 with no bubble.
    req = 4'b0101;
    set_xfer(1'b1, 1'b1, 1'b1);
    step(); expect_grant("rr1_a", 4'b0001, 2'd0);
    step(); expect_grant("rr1_b", 4'b0100, 2'd2);
    step(); expect_grant("rr1_c", 4'b0001, 2'd0);
    step(); expect_grant("rr1_d", 4'b0100, 2'd2);
    req = 4'b0000;
    step(); expect_grant("rr1_idle", 4'b0000, 2'd0);
    step(); expect_grant("idle_ignores_xfer", 4'b0000, 2'd0);

    // Pointer is 3 after the grant to 2: all requesting gives 3, 0, 1, 2.
    req = 4'b1111;
    step(); expect_grant("all_a", 4'b1000, 2'd3);
    step(); expect_grant("all_b", 4'b0001, 2'd0);
    step(); expect_grant("all_c", 4'b0010, 2'd1);
    step(); expect_grant("all_d", 4'b0100, 2'd2);
    req = 4'b0000;
    step(); expect_grant("all_idle", 4'b0000, 2'd0);

    // Multi-beat transaction for requester 1 with stalls; req drops mid-transaction.
    set_xfer(1'b0, 1'b0, 1'b0);
    req = 4'b0010;
    step(); expect_grant("mb_start", 4'b0010, 2'd1);
    set_xfer(1'b1, 1'b1, 1'b0);
    step(); expect_grant("mb_beat1", 4'b0010, 2'd1);
    req = 4'b0000;
    set_xfer(1'b1, 1'b0, 1'b0);
    step(); expect_grant("mb_stall1", 4'b0010, 2'd1);
    step(); expect_grant("mb_stall2", 4'b0010, 2'd1);
    set_xfer(1'b1, 1'b1, 1'b0);
    step(); expect_grant("mb_beat2", 4'b0010, 2'd1);
    set_xfer(1'b1, 1'b0, 1'b1);
    step(); expect_grant("mb_last_notready", 4'b0010, 2'd1);
    set_xfer(1'b0, 1'b1, 1'b1);
    step(); expect_grant("mb_last_notvalid", 4'b0010, 2'd1);
    set_xfer(1'b1, 1'b1, 1'b1);
    step(); expect_grant("mb_done", 4'b0000, 2'd0);

    // Asynchronous reset while busy drops the grant between edges.
    set_xfer(1'b0, 1'b0, 1'b0);
    req = 4'b0100;
    step(); expect_grant("ar_busy", 4'b0100, 2'd2);
    #2 rst_n = 1'b0;
    #1 expect_grant("ar_async", 4'b0000, 2'd0);
    req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    step(); expect_grant("ar_ptr0", 4'b0010, 2'd1);
    set_xfer(1'b1, 1'b1, 1'b1);
    req = 4'b1000;
    step(); expect_grant("ar_req3", 4'b1000, 2'd3);
    req = 4'b0000;
    step(); expect_grant("ar_idle", 4'b0000, 2'd0);

`ifdef ARB_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("st_reset", grant_count, 32'd0);
    req = 4'b0001;
    repeat (3) step();
    check("st_count3", 32'(grant_count[3:0]), 32'd3);
    repeat (14) step();
    check("st_sat", 32'(grant_count[3:0]), 32'd15);
    check("st_others", 32'(grant_count[15:4]), 32'd0);
    stats_clr = 1'b1;
    step();
    check("st_clr_wins", 32'(grant_count[3:0]), 32'd0);
    stats_clr = 1'b0;
    step();
    check("st_after_clr", 32'(grant_count[3:0]), 32'd1);
`else
    req = 4'b0001;
    stats_clr = 1'b1;
    step();
    expect_grant("nostats_grant", 4'b0001, 2'd0);
    check("nostats_count", grant_count, 32'd0);
    stats_clr = 1'b0;
    step();
    check("nostats_count2", grant_count, 32'd0);
`endif
    req = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
